// File: rtl/dtmr_pkg.sv
// Shared constants for the dynamic-TMR mode scheduler: FSM state encodings,
// default parameter values and small enable-decode helpers.
package dtmr_pkg;

  localparam int unsigned WARMUP_DEF   = 4;
  localparam int unsigned HOLD_DEF     = 16;
  localparam int unsigned FAULT_TH_DEF = 3;
  localparam int unsigned WIN_DEF      = 64;
  localparam int unsigned ERR_TH_DEF   = 2;

  localparam int unsigned FSM_W  = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned FCNT_W = 4;
  localparam int unsigned NREP   = 3;

  localparam logic [FSM_W-1:0] ST_SIMPLEX  = 3'd0;
  localparam logic [FSM_W-1:0] ST_WARMUP   = 3'd1;
  localparam logic [FSM_W-1:0] ST_TMR      = 3'd2;
  localparam logic [FSM_W-1:0] ST_HOLD     = 3'd3;
  localparam logic [FSM_W-1:0] ST_DEGRADED = 3'd4;

  function automatic logic [NREP-1:0] onehot3(input logic [1:0] idx);
    case (idx)
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  // Enable for the lowest-index replica not flagged faulty; none if all are.
  function automatic logic [NREP-1:0] lowest_healthy(input logic [NREP-1:0] flt);
    if (!flt[0])      return 3'b001;
    else if (!flt[1]) return 3'b010;
    else if (!flt[2]) return 3'b100;
    else              return 3'b000;
  endfunction

endpackage

// File: rtl/err_window.sv
// Voter error-rate window: counts mismatch cycles over WIN cycles and
// publishes the completed window's count on o_err_rate.
module err_window
  import dtmr_pkg::*;
#(
  parameter int unsigned WIN = WIN_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_err,
  output logic [CNT_W-1:0] o_err_rate
);

  logic [CNT_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_err_rate;
  logic [CNT_W-1:0] w_err_cnt_inc;
  logic             w_wrap;

  assign w_err_cnt_inc = (i_err && (r_err_cnt != 8'hFF)) ? r_err_cnt + 8'd1 : r_err_cnt;
  assign w_wrap        = (r_win_cnt == 8'(WIN - 1));

  // The wrap cycle's own error is folded into the published rate.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_win_cnt  <= '0;
      r_err_cnt  <= '0;
      r_err_rate <= '0;
    end else if (w_wrap) begin
      r_win_cnt  <= '0;
      r_err_cnt  <= '0;
      r_err_rate <= w_err_cnt_inc;
    end else begin
      r_win_cnt  <= r_win_cnt + 8'd1;
      r_err_cnt  <= w_err_cnt_inc;
    end
  end

  assign o_err_rate = r_err_rate;

endmodule

// File: rtl/dtmr_sched.sv
// Dynamic-TMR mode scheduler: steers replica enables and voter activity.
// Optional simplex rotation compiled in with DTMR_SCHED_ROTATE_EN.
module dtmr_sched
  import dtmr_pkg::*;
#(
  parameter int unsigned WARMUP   = WARMUP_DEF,
  parameter int unsigned HOLD     = HOLD_DEF,
  parameter int unsigned FAULT_TH = FAULT_TH_DEF,
  parameter int unsigned WIN      = WIN_DEF,
  parameter int unsigned ERR_TH   = ERR_TH_DEF
`ifdef DTMR_SCHED_ROTATE_EN
  ,
  parameter int unsigned ROT_PERIOD = 256
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f1,
  input  logic             f2,
  input  logic             b1,
  input  logic             b2,
  input  logic             vote_valid,
  input  logic [NREP-1:0]  mismatch,
  input  logic             clr_fault,
  output logic [NREP-1:0]  en,
  output logic             state,
  output logic [NREP-1:0]  fault,
  output logic [CNT_W-1:0] err_rate
);

  logic [FSM_W-1:0]             r_fsm;
  logic [FSM_W-1:0]             w_fsm_next;
  logic [CNT_W-1:0]             r_cnt;
  logic [NREP-1:0]              r_en;
  logic [NREP-1:0]              w_en_next;
  logic                         r_state;
  logic                         w_state_next;
  logic [NREP-1:0]              r_fault;
  logic [NREP-1:0]              w_fault_next;
  logic [NREP-1:0][FCNT_W-1:0]  r_fcnt;
  logic [NREP-1:0][FCNT_W-1:0]  w_fcnt_next;
  logic [CNT_W-1:0]             w_err_rate;
  logic [1:0]                   w_active_next;
  logic                         w_hot;

  err_window #(.WIN(WIN)) u_err_window (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_err      (vote_valid & (|mismatch)),
    .o_err_rate (w_err_rate)
  );

  assign w_hot = (~f1 | ~f2 | ~b1 | ~b2) | (w_err_rate >= 8'(ERR_TH));

`ifdef DTMR_SCHED_ROTATE_EN
  localparam int unsigned ROT_W = $clog2(ROT_PERIOD);
  logic [ROT_W-1:0] r_rot_cnt;
  logic [1:0]       r_active;
  logic             w_rot_wrap;

  assign w_rot_wrap = (r_fsm == ST_SIMPLEX) && (r_rot_cnt == ROT_W'(ROT_PERIOD - 1));

  always_comb begin
    w_active_next = r_active;
    if (clr_fault)       w_active_next = 2'd0;
    else if (w_rot_wrap) w_active_next = (r_active == 2'd2) ? 2'd0 : r_active + 2'd1;
  end

  // Rotation counter only runs in SIMPLEX and restarts on each entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rot_cnt <= '0;
      r_active  <= 2'd0;
    end else begin
      r_active <= w_active_next;
      if (r_fsm != ST_SIMPLEX) begin
        if (w_fsm_next == ST_SIMPLEX) r_rot_cnt <= '0;
      end else if (w_rot_wrap) begin
        r_rot_cnt <= '0;
      end else begin
        r_rot_cnt <= r_rot_cnt + ROT_W'(1);
      end
    end
  end
`else
  assign w_active_next = 2'd0;
`endif

  // Per-replica saturating mismatch counters and latched fault flags.
  always_comb begin
    for (int i = 0; i < int'(NREP); i++) begin
      w_fcnt_next[i] = r_fcnt[i];
      if (vote_valid && mismatch[i] && (r_fcnt[i] != 4'hF))
        w_fcnt_next[i] = r_fcnt[i] + 4'd1;
      w_fault_next[i] = r_fault[i] | (w_fcnt_next[i] >= 4'(FAULT_TH));
    end
  end

  always_comb begin
    w_fsm_next   = r_fsm;
    w_en_next    = 3'b111;
    w_state_next = 1'b0;
    case (r_fsm)
      ST_SIMPLEX: begin
        if (r_fault != '0) w_fsm_next = ST_DEGRADED;
        else if (w_hot)    w_fsm_next = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (r_cnt == 8'(WARMUP - 1)) w_fsm_next = ST_TMR;
      end
      ST_TMR: begin
        if (r_fault != '0) w_fsm_next = ST_DEGRADED;
        else if (!w_hot)   w_fsm_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (r_fault != '0)              w_fsm_next = ST_DEGRADED;
        else if (w_hot)                 w_fsm_next = ST_TMR;
        else if (r_cnt == 8'(HOLD - 1)) w_fsm_next = ST_SIMPLEX;
      end
      ST_DEGRADED: begin
        if (clr_fault) w_fsm_next = ST_SIMPLEX;
      end
      default: w_fsm_next = ST_SIMPLEX;
    endcase

    // Outputs are registered from the state being entered.
    case (w_fsm_next)
      ST_SIMPLEX:  w_en_next = onehot3(w_active_next);
      ST_TMR,
      ST_HOLD:     w_state_next = 1'b1;
      ST_DEGRADED: w_en_next = lowest_healthy(r_fault);
      default:     w_en_next = 3'b111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= ST_SIMPLEX;
      r_cnt   <= '0;
      r_en    <= 3'b001;
      r_state <= 1'b0;
      r_fault <= '0;
      r_fcnt  <= '0;
    end else begin
      r_fsm   <= w_fsm_next;
      r_cnt   <= (w_fsm_next != r_fsm) ? '0 : r_cnt + 8'd1;
      r_en    <= w_en_next;
      r_state <= w_state_next;
      if (clr_fault) begin
        r_fault <= '0;
        r_fcnt  <= '0;
      end else begin
        r_fault <= w_fault_next;
        r_fcnt  <= w_fcnt_next;
      end
    end
  end

  assign en       = r_en;
  assign state    = r_state;
  assign fault    = r_fault;
  assign err_rate = w_err_rate;

endmodule

// File: tb/tb_dtmr_sched.sv
// Directed bench for dtmr_sched (default build, default parameters).
module tb_dtmr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       f1, f2, b1, b2;
  logic       vote_valid;
  logic [2:0] mismatch;
  logic       clr_fault;
  logic [2:0] en;
  logic       state;
  logic [2:0] fault;
  logic [7:0] err_rate;

  int n_assert = 0;
  int n_fail   = 0;
  int e        = 0;

  always #5 clk = ~clk;

  dtmr_sched dut (
    .clk        (clk),
    .rst        (rst),
    .f1         (f1),
    .f2         (f2),
    .b1         (b1),
    .b2         (b2),
    .vote_valid (vote_valid),
    .mismatch   (mismatch),
    .clr_fault  (clr_fault),
    .en         (en),
    .state      (state),
    .fault      (fault),
    .err_rate   (err_rate)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (edge %0d): observed 0x%0h expected 0x%0h", tag, e, obs, exp);
    end
  endtask

  // e counts rising edges since reset release; outputs sampled 1 time unit after.
  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int k);
    while (e < k) tick();
  endtask

  task automatic idle_in();
    f1 = 1'b1; f2 = 1'b1; b1 = 1'b1; b2 = 1'b1;
    vote_valid = 1'b0; mismatch = 3'b000; clr_fault = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    chk("rst_en",    {5'd0, en},    8'h01);
    chk("rst_state", {7'd0, state}, 8'h00);
    chk("rst_fault", {5'd0, fault}, 8'h00);
    chk("rst_err",   err_rate,      8'h00);
    tick();
    rst = 1'b0;
    e   = 0;
  endtask

  task automatic vote(input logic [2:0] mm);
    vote_valid = 1'b1;
    mismatch   = mm;
  endtask

  task automatic novote();
    vote_valid = 1'b0;
    mismatch   = 3'b000;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;

    // Idle: stays simplex with no errors
    do_reset();
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_en",    {5'd0, en},    8'h01);
      chk("idle_state", {7'd0, state}, 8'h00);
      chk("idle_err",   err_rate,      8'h00);
    end

    // Escalation on f1, then HOLD expiry back to simplex
    do_reset();
    run_to(9);  f1 = 1'b0;
    run_to(10); chk("esc_en", {5'd0, en}, 8'h07); chk("esc_state0", {7'd0, state}, 8'h00);
    run_to(13); chk("warm_state", {7'd0, state}, 8'h00);
    run_to(14); chk("tmr_state", {7'd0, state}, 8'h01); chk("tmr_en", {5'd0, en}, 8'h07);
    run_to(29); f1 = 1'b1;
    run_to(30); chk("hold_state", {7'd0, state}, 8'h01);
    run_to(45); chk("hold_late_state", {7'd0, state}, 8'h01); chk("hold_late_en", {5'd0, en}, 8'h07);
    run_to(46); chk("deesc_state", {7'd0, state}, 8'h00); chk("deesc_en", {5'd0, en}, 8'h01);
    run_to(47); chk("simplex_en", {5'd0, en}, 8'h01);

    // HOLD interrupted by hot: counter restarts on re-entry
    do_reset();
    run_to(0);  f2 = 1'b0;
    run_to(5);  f2 = 1'b1;
    run_to(6);  chk("b2_hold", {7'd0, state}, 8'h01);
    run_to(9);  f2 = 1'b0;
    run_to(10); f2 = 1'b1;
    run_to(26); chk("rehold_state", {7'd0, state}, 8'h01);
    run_to(27); chk("rehold_exit", {7'd0, state}, 8'h00); chk("rehold_en", {5'd0, en}, 8'h01);

    // Replica 1 faults in TMR, degrade, then clear
    do_reset();
    f1 = 1'b0;
    run_to(5);  vote(3'b010);
    run_to(7);  chk("flt1_pre", {5'd0, fault}, 8'h00);
    run_to(8);  novote(); chk("flt1_set", {5'd0, fault}, 8'h02); chk("flt1_state", {7'd0, state}, 8'h01);
    run_to(9);  chk("deg_en", {5'd0, en}, 8'h01); chk("deg_state", {7'd0, state}, 8'h00);
    run_to(10); chk("deg_stay", {5'd0, en}, 8'h01);
    clr_fault = 1'b1;
    run_to(11); clr_fault = 1'b0;
    chk("clr_fault", {5'd0, fault}, 8'h00); chk("clr_en", {5'd0, en}, 8'h01); chk("clr_state", {7'd0, state}, 8'h00);
    run_to(12); chk("clr_rewarm", {5'd0, en}, 8'h07);

    // Replicas 0 and 1 fault together: degraded picks replica 2
    do_reset();
    b2 = 1'b0;
    run_to(4);  vote(3'b011);
    run_to(7);  novote(); chk("flt01_set", {5'd0, fault}, 8'h03);
    run_to(8);  chk("deg2_en", {5'd0, en}, 8'h04); chk("deg2_state", {7'd0, state}, 8'h00);

    // clr_fault beats a same-cycle threshold crossing and clears counters
    do_reset();
    b1 = 1'b0;
    run_to(4);  vote(3'b010);
    run_to(6);  clr_fault = 1'b1;
    run_to(7);  clr_fault = 1'b0; chk("clr_race", {5'd0, fault}, 8'h00);
    run_to(9);  chk("clr_cnt_low", {5'd0, fault}, 8'h00);
    run_to(10); novote(); chk("clr_cnt_recount", {5'd0, fault}, 8'h02);

    // Two mismatch cycles in one window escalate via err_rate
    do_reset();
    run_to(9);  vote(3'b001);
    run_to(10); novote();
    run_to(19); vote(3'b100);
    run_to(20); novote();
    run_to(63); chk("win_pre", err_rate, 8'h00); chk("win_pre_en", {5'd0, en}, 8'h01);
    run_to(64); chk("win_rate2", err_rate, 8'h02); chk("win_en_simplex", {5'd0, en}, 8'h01);
    run_to(65); chk("win_warm_en", {5'd0, en}, 8'h07); chk("win_warm_state", {7'd0, state}, 8'h00);

    // Error on the wrap cycle itself counts; next window reads zero
    do_reset();
    run_to(63); vote(3'b010);
    run_to(64); novote(); chk("wrap_rate1", err_rate, 8'h01);
    run_to(65); chk("wrap_not_hot", {5'd0, en}, 8'h01);
    run_to(128); chk("wrap_next_win", err_rate, 8'h00);

    // Reset from a non-idle state restores reset values
    f1 = 1'b0;
    run_to(135);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dtmr_sched.md
# dtmr_sched

Mode scheduler for the dynamic-TMR steering path. Decides, cycle by cycle, which of the three PMC replicas are enabled and whether the majority voter is active. Escalates from simplex to full TMR on obstacle detection or an elevated voter error rate, and tracks per-replica mismatch counts to retire faulty replicas. It sits between the sensor inputs and the PMC replicas and voter, replacing ad-hoc enable logic.

## Interface
- WARMUP, 4: cycles all replicas run before voting starts (1..255)
- HOLD, 16: quiet cycles in TMR before dropping back to simplex (1..255)
- FAULT_TH, 3: cumulative mismatches that mark a replica faulty (1..15)
- WIN, 64: error-rate window length in cycles (2..255)
- ERR_TH, 2: err_rate at or above this value forces TMR (1..255)
- ROT_PERIOD, 256: simplex rotation period (only with rotation compiled in)
- clk  in  1  system clock; the only clock
- rst  in  1  reset, synchronous, active-high
- f1, f2, b1, b2  in  1 each  obstacle sensors, active low
- vote_valid  in  1  voter produced a valid vote this cycle
- mismatch  in  3  bit i: replica i disagreed with the majority (qualified by vote_valid)
- clr_fault  in  1  single-cycle pulse; clears fault state
- en  out  3  replica enables, bit i drives PMC i
- state  out  1  1 = voter active (TMR); 0 = simplex pass-through
- fault  out  3  latched faulty-replica flags
- err_rate  out  8  mismatch-cycle count from the last completed window

## Operation
- obstacle = ~f1 | ~f2 | ~b1 | ~b2. hot = obstacle | (err_rate >= ERR_TH). healthy = ~fault.
- FSM states: SIMPLEX, WARMUP, TMR, HOLD, DEGRADED.
- SIMPLEX: en = onehot(active), state=0. If hot and fault==0, go to WARMUP. If fault != 0, go to DEGRADED.
- WARMUP: en=111, state=0. Counts WARMUP cycles, then goes to TMR. Loss of obstacle does not abort warmup.
- TMR: en=111, state=1. If any fault bit is set, go to DEGRADED. Otherwise, if !hot, go to HOLD.
- HOLD: en=111, state=1, counter runs. If hot, return to TMR and the counter restarts on the next entry. When the counter reaches HOLD, go to SIMPLEX. A fault goes to DEGRADED (priority over the other exits).
- DEGRADED: state=0, en = onehot(lowest-index healthy replica), or 000 if all are faulty. The only exit is clr_fault, which goes to SIMPLEX.
- Fault counters: one 4-bit saturating counter per replica. It increments when vote_valid & mismatch[i]. When it reaches FAULT_TH, fault[i] sets and remains latched.
- clr_fault: clears all counters and fault bits. It wins over a same-cycle increment or threshold crossing.
- Error window: the cycle counter wraps at WIN-1. The error count increments on cycles with vote_valid & |mismatch, saturating at 255. At wrap, err_rate is loaded with the count (including the wrap cycle) and the count restarts at 0.
- Simplex active index: 0 after reset, and after clr_fault.

## Timing
- All outputs are registered.
- Reset values: FSM=SIMPLEX, en=001, state=0, fault=000, err_rate=0. All counters are 0.
- Escalation latency:
  - Sensor low sampled at edge n → en=111 from n+1.
  - state=1 from n+1+WARMUP.
- Fault latency: the mismatch that brings the count to FAULT_TH, sampled at edge n, gives:
  - fault[i]=1 at n+1;
  - FSM=DEGRADED with state=0 and the new en at n+2.
- De-escalation: the first quiet cycle in TMR leads to HOLD the next cycle. SIMPLEX is entered after HOLD further quiet cycles.
- A reset asserted in any state returns everything to the reset values at the next edge. An in-flight window is discarded.

## Configuration
- DTMR_SCHED_ROTATE_EN defined: in SIMPLEX, active advances to the next replica every ROT_PERIOD cycles, wrapping 2→0. The rotation counter holds while not in SIMPLEX and resets on SIMPLEX entry.
- Not defined: active is fixed at 0 and there is no rotation counter.

## Structure
- Shared package dtmr_pkg: the FSM state enum and the default parameter constants (WARMUP, HOLD, FAULT_TH, WIN, ERR_TH).
- One sub-module, err_window: the window cycle counter, the error count, and the err_rate register.
- Everything else lives in dtmr_sched.

## Test plan
- Reset, then all sensors high for 100 cycles → en=001, state=0, err_rate=0 throughout.
- f1 low at edge 10, defaults → en=111 at 11, state=1 at 15. Release f1 at 30 → state stays 1 until HOLD expires (SIMPLEX, en=001, state=0 by edge 48).
- In TMR, three vote_valid cycles with mismatch=010 → fault=010 one cycle after the third; en=001, state=0 the cycle after that. clr_fault → fault=000, SIMPLEX.
- clr_fault asserted in the same cycle as the third mismatch → fault stays 000 and the counter is cleared.
- Two mismatch cycles inside one WIN window with sensors clear → err_rate=2 at the wrap, FSM enters WARMUP the following cycle.
- With DTMR_SCHED_ROTATE_EN and ROT_PERIOD=8, idle → en sequence 001, 010, 100, 001, changing every 8 cycles.
